// File: rtl/ram_2r_w_ctl_pkg.sv
// ----------------------------------------------------------------------------
// ram_2r_w_ctl_pkg
// Shared declarations for the 2-read/1-write RAM broadcast-FIFO controller:
//   - wr_state_t : write-side FSM states (W_IDLE, W_COMMIT)
//   - clog2      : constant function used to size pointers
//   - ptr_t      : pointer type for the default 8-entry configuration
// No ports (package).
// ----------------------------------------------------------------------------
package ram_2r_w_ctl_pkg;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_COMMIT = 1'b1
    } wr_state_t;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int DEFAULT_DEPTH = 8;
    // One extra bit beyond the address distinguishes full from empty.
    localparam int PTR_WIDTH     = clog2(DEFAULT_DEPTH) + 1;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/ram_2r_w_rdport.sv
// ----------------------------------------------------------------------------
// ram_2r_w_rdport
// One reader of the broadcast FIFO. Owns the reader pointer, generates the
// output valid, presents the async RAM read data, and reports whether this
// reader is holding the FIFO full.
// Optional build macro: RAM_2R_W_CTL_LEVEL_EN adds the 'level' output
// (committed words still pending for this reader).
// Ports:
//   clk, rst, flush     clock, sync active-high reset, pointer clear
//   wr_ptr, cm_ptr      accept and committed pointers from the write side
//   valid/ready/data    reader stream
//   ram_addr, ram_data  RAM read port (address out, async data in)
//   full                this reader has DEPTH unconsumed accepted words
//   level               (optional) cm_ptr - rd_ptr
// ----------------------------------------------------------------------------
module ram_2r_w_rdport
    import ram_2r_w_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic [ADDR_WIDTH:0]   cm_ptr,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  full
`ifdef RAM_2R_W_CTL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
        end else if (valid && ready) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Only committed words are visible, so the reader never sees a slot that
    // is still being written.
    assign valid    = (rd_ptr != cm_ptr);
    assign data     = ram_data;
    assign ram_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Occupancy counts against the accept pointer so a staged (not yet
    // committed) word already reserves its slot.
    assign cnt  = wr_ptr - rd_ptr;
    assign full = (cnt == DEPTH_P);

`ifdef RAM_2R_W_CTL_LEVEL_EN
    assign level = cm_ptr - rd_ptr;
`endif

endmodule

// File: rtl/ram_2r_w_ctl.sv
// ----------------------------------------------------------------------------
// ram_2r_w_ctl
// Controller that turns an external 2-read/1-write latch RAM into a
// broadcast FIFO: one valid/ready producer stream, two independent
// valid/ready consumer streams that each see every word in order. A slot is
// reused only after both readers have consumed it.
// Optional build macro: RAM_2R_W_CTL_LEVEL_EN adds level1/level2 outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all entries, clear all pointers
//   in_valid/in_ready/in_data         producer stream
//   out1_valid/out1_ready/out1_data   reader 1 stream
//   out2_valid/out2_ready/out2_data   reader 2 stream
//   ram_rst_n           RAM reset (~rst)
//   ram_cs_n, ram_wr_n  RAM write strobe (active low)
//   ram_wr_addr, ram_data_in          RAM write address/data
//   ram_rd1_addr/ram_rd1_data         RAM read port 1
//   ram_rd2_addr/ram_rd2_data         RAM read port 2
//   level1, level2      (optional) committed words pending per reader
// ----------------------------------------------------------------------------
module ram_2r_w_ctl
    import ram_2r_w_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic                  ram_rst_n,
    output logic                  ram_cs_n,
    output logic                  ram_wr_n,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd1_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd2_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_rd1_data,
    input  logic [DATA_WIDTH-1:0] ram_rd2_data
`ifdef RAM_2R_W_CTL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level1,
    output logic [ADDR_WIDTH:0]   level2
`endif
);

    if (clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_cfg
        $error("ram_2r_w_ctl: ADDR_WIDTH must equal log2(DEPTH)");
    end

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

    wr_state_t             state;
    wr_state_t             state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   cm_ptr;
    logic [DATA_WIDTH-1:0] stage_data;
    logic [ADDR_WIDTH-1:0] stage_addr;
    logic                  rst_q;
    logic                  full1;
    logic                  full2;
    logic                  accept;
    logic                  commit;

    // rst_q holds in_ready low for one extra cycle after reset releases.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign in_ready = ~(full1 | full2) & ~flush & ~rst & ~rst_q;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= W_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // commit is gated by flush/rst so a pending write is dropped without
    // ever strobing the RAM in that cycle.
    always_comb begin
        state_nxt = W_IDLE;
        commit    = 1'b0;
        case (state)
            W_IDLE: begin
                if (accept) begin
                    state_nxt = W_COMMIT;
                end
            end
            W_COMMIT: begin
                commit = ~flush & ~rst;
                if (accept) begin
                    state_nxt = W_COMMIT;
                end
            end
            default: begin
                state_nxt = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                cm_ptr <= cm_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data <= '0;
            stage_addr <= '0;
        end else if (accept) begin
            stage_data <= in_data;
            stage_addr <= wr_ptr[ADDR_WIDTH-1:0];
        end
    end

    assign ram_rst_n   = ~rst;
    assign ram_cs_n    = ~commit;
    assign ram_wr_n    = ~commit;
    assign ram_wr_addr = stage_addr;
    assign ram_data_in = stage_data;

    ram_2r_w_rdport #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_ptr   (wr_ptr),
        .cm_ptr   (cm_ptr),
        .valid    (out1_valid),
        .ready    (out1_ready),
        .data     (out1_data),
        .ram_addr (ram_rd1_addr),
        .ram_data (ram_rd1_data),
        .full     (full1)
`ifdef RAM_2R_W_CTL_LEVEL_EN
        ,
        .level    (level1)
`endif
    );

    ram_2r_w_rdport #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_ptr   (wr_ptr),
        .cm_ptr   (cm_ptr),
        .valid    (out2_valid),
        .ready    (out2_ready),
        .data     (out2_data),
        .ram_addr (ram_rd2_addr),
        .ram_data (ram_rd2_data),
        .full     (full2)
`ifdef RAM_2R_W_CTL_LEVEL_EN
        ,
        .level    (level2)
`endif
    );

endmodule
